// File: rtl/reg_file_scoreboard_pkg.sv
// Shared sizes and the source-hazard rule for the register file scoreboard.
package reg_file_scoreboard_pkg;

  localparam int REG_COUNT = 16;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 4;
  localparam int CNT_W     = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(3);

  // A source is hazardous while a write is outstanding, unless the last one lands this cycle.
  function automatic logic src_hazard(
    input logic              used,
    input logic [ADDR_W-1:0] addr,
    input logic [CNT_W-1:0]  cnt,
    input logic              wb,
    input logic [ADDR_W-1:0] wb_rd
  );
    return used && (addr != '0) && (cnt != '0) &&
           !((cnt == CNT_W'(1)) && wb && (wb_rd == addr));
  endfunction

endpackage

// File: rtl/reg_file_scoreboard_sb_counter.sv
// Saturating 2-bit outstanding-write counter; simultaneous inc and dec cancel.
module sb_counter
  import reg_file_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// 16x16 register file with write-back bypass and a per-register outstanding-write
// scoreboard that stalls issue on source hazards and destination counter overflow.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rest,
  input  logic                 Freze,
  input  logic                 RegWrite,
  input  logic [ADDR_W-1:0]    Rd_In,
  input  logic [DATA_W-1:0]    WriteDataRegFile,
  input  logic [ADDR_W-1:0]    Rs_Addr,
  input  logic [ADDR_W-1:0]    Rt_Addr,
  input  logic                 Rs_Used,
  input  logic                 Rt_Used,
  output logic [DATA_W-1:0]    Rs_Data,
  output logic [DATA_W-1:0]    Rt_Data,
  input  logic                 Issue_Valid,
  input  logic                 Issue_RegWrite,
  input  logic [ADDR_W-1:0]    Issue_Rd,
  output logic                 Stall,
  output logic [REG_COUNT-1:0] Pending
);

  logic [DATA_W-1:0] rf_q [REG_COUNT];
  logic [CNT_W-1:0]  cnt  [REG_COUNT];
  logic              wb_en;
  logic              issue_acc;
  logic              rs_haz;
  logic              rt_haz;
  logic              rd_full;
  logic              byp_rs;
  logic              byp_rt;

  assign wb_en      = RegWrite && (Rd_In != '0);
  assign rf_q[0]    = '0;
  assign cnt[0]     = '0;
  assign Pending[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_reg
      logic [DATA_W-1:0] data_d;
      logic [DATA_W-1:0] data_q;
      logic              inc;
      logic              dec;

      always_comb begin
        data_d = data_q;
        if (wb_en && (Rd_In == ADDR_W'(gi))) begin
          data_d = WriteDataRegFile;
        end
      end

      always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign inc = issue_acc && Issue_RegWrite && (Issue_Rd == ADDR_W'(gi));
      assign dec = wb_en && (Rd_In == ADDR_W'(gi)) && (cnt[gi] != '0);

      sb_counter u_cnt (
        .clk   (clk),
        .clr_n (rest),
        .inc   (inc),
        .dec   (dec),
        .count (cnt[gi])
      );

      assign rf_q[gi]    = data_q;
      assign Pending[gi] = (cnt[gi] != '0);
    end
  endgenerate

  always_comb begin
    rs_haz  = src_hazard(Rs_Used, Rs_Addr, cnt[Rs_Addr], RegWrite, Rd_In);
    rt_haz  = src_hazard(Rt_Used, Rt_Addr, cnt[Rt_Addr], RegWrite, Rd_In);
    // A full destination counter frees a slot only if its write-back lands now.
    rd_full = Issue_RegWrite && (Issue_Rd != '0) && (cnt[Issue_Rd] == CNT_MAX) &&
              !(RegWrite && (Rd_In == Issue_Rd));
    Stall   = Issue_Valid && (rs_haz || rt_haz || rd_full);
  end

  assign issue_acc = Issue_Valid && !Stall && !Freze;

  // Bypass is suppressed while reset is held so reads stay zero.
  assign byp_rs  = rest && wb_en && (Rd_In == Rs_Addr);
  assign byp_rt  = rest && wb_en && (Rd_In == Rt_Addr);
  assign Rs_Data = byp_rs ? WriteDataRegFile : rf_q[Rs_Addr];
  assign Rt_Data = byp_rt ? WriteDataRegFile : rf_q[Rt_Addr];

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench: directed scenarios plus a randomized run against a reference model.
module tb_reg_file_scoreboard;

  logic        clk;
  logic        rest;
  logic        Freze;
  logic        RegWrite;
  logic [3:0]  Rd_In;
  logic [15:0] WriteDataRegFile;
  logic [3:0]  Rs_Addr;
  logic [3:0]  Rt_Addr;
  logic        Rs_Used;
  logic        Rt_Used;
  logic [15:0] Rs_Data;
  logic [15:0] Rt_Data;
  logic        Issue_Valid;
  logic        Issue_RegWrite;
  logic [3:0]  Issue_Rd;
  logic        Stall;
  logic [15:0] Pending;

  int tests_run;
  int tests_failed;

  logic [15:0] m_rf  [16];
  logic [1:0]  m_cnt [16];
  logic [31:0] exp_q [$];

  reg_file_scoreboard dut (
    .clk              (clk),
    .rest             (rest),
    .Freze            (Freze),
    .RegWrite         (RegWrite),
    .Rd_In            (Rd_In),
    .WriteDataRegFile (WriteDataRegFile),
    .Rs_Addr          (Rs_Addr),
    .Rt_Addr          (Rt_Addr),
    .Rs_Used          (Rs_Used),
    .Rt_Used          (Rt_Used),
    .Rs_Data          (Rs_Data),
    .Rt_Data          (Rt_Data),
    .Issue_Valid      (Issue_Valid),
    .Issue_RegWrite   (Issue_RegWrite),
    .Issue_Rd         (Issue_Rd),
    .Stall            (Stall),
    .Pending          (Pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic model_stall();
    logic rs_h, rt_h, rd_f;
    rs_h = Rs_Used && Rs_Addr != 0 && m_cnt[Rs_Addr] != 0 &&
           !(m_cnt[Rs_Addr] == 1 && RegWrite && Rd_In == Rs_Addr);
    rt_h = Rt_Used && Rt_Addr != 0 && m_cnt[Rt_Addr] != 0 &&
           !(m_cnt[Rt_Addr] == 1 && RegWrite && Rd_In == Rt_Addr);
    rd_f = Issue_RegWrite && Issue_Rd != 0 && m_cnt[Issue_Rd] == 3 &&
           !(RegWrite && Rd_In == Issue_Rd);
    return Issue_Valid && (rs_h || rt_h || rd_f);
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] a);
    if (a == 0) return 16'h0000;
    if (rest && RegWrite && Rd_In == a) return WriteDataRegFile;
    return m_rf[a];
  endfunction

  function automatic logic [15:0] model_pending();
    logic [15:0] p;
    p = '0;
    for (int i = 1; i < 16; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_rf[i]  = '0;
      m_cnt[i] = '0;
    end
  endtask

  task automatic idle();
    Freze = 0; RegWrite = 0; Rd_In = 0; WriteDataRegFile = 0;
    Rs_Addr = 0; Rt_Addr = 0; Rs_Used = 0; Rt_Used = 0;
    Issue_Valid = 0; Issue_RegWrite = 0; Issue_Rd = 0;
  endtask

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic tick();
    logic acc, inc, dec;
    if (rest) begin
      acc = Issue_Valid && !model_stall() && !Freze;
      for (int i = 1; i < 16; i++) begin
        inc = acc && Issue_RegWrite && Issue_Rd == i[3:0];
        dec = RegWrite && Rd_In == i[3:0] && m_cnt[i] != 0;
        if (inc && !dec) m_cnt[i] = m_cnt[i] + 2'd1;
        else if (dec && !inc) m_cnt[i] = m_cnt[i] - 2'd1;
      end
      if (RegWrite && Rd_In != 0) m_rf[Rd_In] = WriteDataRegFile;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rest = 0;
    idle();
    model_clear();
    Issue_Valid = 1; Rs_Used = 1; Rs_Addr = 3;
    @(negedge clk);
    #1;
    tests_run++;
    if (Pending !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_pending: got %h want 0000", Pending);
    end
    tests_run++;
    if (Stall !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall: got %b want 0", Stall);
    end
    exp_q.push_back({16'h0000, 16'h0000});
    e = exp_q.pop_front();
    tests_run++;
    if ({Rs_Data, Rt_Data} !== e) begin
      tests_failed++; $display("FAIL reset_read: got %h want %h", {Rs_Data, Rt_Data}, e);
    end
    @(negedge clk);
    rest = 1;
    idle();
    #1;
    $display("[TB] reset done");
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    idle();
    RegWrite = 1; Rd_In = 3; WriteDataRegFile = 16'h1234;
    tick();
    idle();
    Rs_Addr = 3; Rt_Addr = 3;
    exp_q.push_back({16'h1234, 16'h1234});
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if ({Rs_Data, Rt_Data} !== e) begin
      tests_failed++; $display("FAIL write_read_r3: got %h want %h", {Rs_Data, Rt_Data}, e);
    end
    RegWrite = 1; Rd_In = 0; WriteDataRegFile = 16'hFFFF;
    tick();
    idle();
    Rs_Addr = 0;
    exp_q.push_back({16'h0000, 16'h0000});
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if ({Rs_Data, Pending} !== e) begin
      tests_failed++; $display("FAIL write_r0: got %h want %h", {Rs_Data, Pending}, e);
    end
    $display("[TB] write/read R3 and R0 checked");
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    idle();
    RegWrite = 1; Rd_In = 5; WriteDataRegFile = 16'hABCD; Rt_Addr = 5; Rs_Addr = 3;
    exp_q.push_back({16'h1234, 16'hABCD});
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if ({Rs_Data, Rt_Data} !== e) begin
      tests_failed++; $display("FAIL bypass: got %h want %h", {Rs_Data, Rt_Data}, e);
    end
    tick();
    idle();
    Rt_Addr = 5;
    #1;
    tests_run++;
    if (Rt_Data !== 16'hABCD) begin
      tests_failed++; $display("FAIL bypass_stored: got %h want abcd", Rt_Data);
    end
    $display("[TB] bypass checked");
  endtask

  task automatic test_stall_pending();
    idle();
    Issue_Valid = 1; Issue_RegWrite = 1; Issue_Rd = 4;
    #1;
    tests_run++;
    if (Stall !== 1'b0) begin
      tests_failed++; $display("FAIL issue_r4_stall: got %b want 0", Stall);
    end
    tick();
    idle();
    Issue_Valid = 1; Rs_Used = 1; Rs_Addr = 4;
    #1;
    tests_run++;
    if ({Stall, Pending[4]} !== 2'b11) begin
      tests_failed++; $display("FAIL raw_r4: got stall=%b pend=%b want 1 1", Stall, Pending[4]);
    end
    RegWrite = 1; Rd_In = 4; WriteDataRegFile = 16'h4444;
    #1;
    tests_run++;
    if ({Stall, Rs_Data} !== {1'b0, 16'h4444}) begin
      tests_failed++; $display("FAIL wb_r4_release: got stall=%b data=%h want 0 4444", Stall, Rs_Data);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (Pending[4] !== 1'b0) begin
      tests_failed++; $display("FAIL pend_r4_clear: got %b want 0", Pending[4]);
    end
    $display("[TB] RAW hazard on R4 checked");
  endtask

  task automatic test_count_max();
    logic [31:0] e;
    idle();
    Issue_Valid = 1; Issue_RegWrite = 1; Issue_Rd = 7;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (Stall !== 1'b0) begin
        tests_failed++; $display("FAIL r7_issue%0d: got stall=%b want 0", k, Stall);
      end
      tick();
    end
    #1;
    tests_run++;
    if ({Stall, Pending[7]} !== 2'b11) begin
      tests_failed++; $display("FAIL r7_full: got stall=%b pend=%b want 1 1", Stall, Pending[7]);
    end
    RegWrite = 1; Rd_In = 7; WriteDataRegFile = 16'h7777;
    #1;
    tests_run++;
    if (Stall !== 1'b0) begin
      tests_failed++; $display("FAIL r7_full_wb: got stall=%b want 0", Stall);
    end
    tick();
    RegWrite = 0;
    #1;
    tests_run++;
    if (Stall !== 1'b1) begin
      tests_failed++; $display("FAIL r7_still_full: got stall=%b want 1", Stall);
    end
    idle();
    RegWrite = 1; Rd_In = 7; WriteDataRegFile = 16'h0707;
    tick();
    tick();
    #1;
    tests_run++;
    if (Pending[7] !== 1'b1) begin
      tests_failed++; $display("FAIL r7_drain2: got %b want 1", Pending[7]);
    end
    tick();
    #1;
    tests_run++;
    if (Pending[7] !== 1'b0) begin
      tests_failed++; $display("FAIL r7_drain3: got %b want 0", Pending[7]);
    end
    WriteDataRegFile = 16'h0708;
    tick();
    idle();
    Rs_Addr = 7;
    exp_q.push_back({16'h0708, 16'h0000});
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if ({Rs_Data, Pending} !== e) begin
      tests_failed++; $display("FAIL r7_wb_at_zero: got %h want %h", {Rs_Data, Pending}, e);
    end
    $display("[TB] R7 counter saturation checked");
  endtask

  task automatic test_freeze();
    idle();
    Freze = 1; Issue_Valid = 1; Issue_RegWrite = 1; Issue_Rd = 2;
    #1;
    tests_run++;
    if (Stall !== 1'b0) begin
      tests_failed++; $display("FAIL freeze_stall: got %b want 0", Stall);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (Pending[2] !== 1'b0) begin
      tests_failed++; $display("FAIL freeze_pend_r2: got %b want 0", Pending[2]);
    end
    $display("[TB] freeze checked");
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [15:0] ep;
    logic        es;
    for (int n = 0; n < 200; n++) begin
      Freze            = ($urandom_range(0, 7) == 0);
      RegWrite         = $urandom_range(0, 1);
      Rd_In            = 4'($urandom_range(0, 6));
      WriteDataRegFile = 16'($urandom);
      Rs_Addr          = 4'($urandom_range(0, 6));
      Rt_Addr          = 4'($urandom_range(0, 6));
      Rs_Used          = ($urandom_range(0, 3) == 0);
      Rt_Used          = ($urandom_range(0, 3) == 0);
      Issue_Valid      = $urandom_range(0, 1);
      Issue_RegWrite   = ($urandom_range(0, 3) != 0);
      Issue_Rd         = 4'($urandom_range(0, 6));
      exp_q.push_back({model_read(Rs_Addr), model_read(Rt_Addr)});
      es = model_stall();
      ep = model_pending();
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if ({Rs_Data, Rt_Data} !== e) begin
        tests_failed++; $display("FAIL b2b_read[%0d]: got %h want %h", n, {Rs_Data, Rt_Data}, e);
      end
      tests_run++;
      if ({Stall, Pending} !== {es, ep}) begin
        tests_failed++; $display("FAIL b2b_stall_pend[%0d]: got %b/%h want %b/%h", n, Stall, Pending, es, ep);
      end
      tick();
    end
    idle();
    $display("[TB] 200 back-to-back random cycles checked");
  endtask

  task automatic test_reset_mid();
    idle();
    RegWrite = 1; Rd_In = 1; WriteDataRegFile = 16'h1111;
    tick();
    idle();
    @(negedge clk);
    rest = 0;
    model_clear();
    @(negedge clk);
    rest = 1;
    RegWrite = 1; Rd_In = 1; WriteDataRegFile = 16'h1111;
    tick();
    idle();
    Issue_Valid = 1; Issue_RegWrite = 1; Issue_Rd = 1;
    tick();
    tick();
    Issue_Rd = 9;
    tick();
    idle();
    Issue_Valid = 1; Rs_Used = 1; Rs_Addr = 1;
    #1;
    tests_run++;
    if ({Stall, Pending, Rs_Data} !== {1'b1, 16'h0202, 16'h1111}) begin
      tests_failed++; $display("FAIL pre_reset: got %b/%h/%h want 1/0202/1111", Stall, Pending, Rs_Data);
    end
    #1;
    rest = 0;
    model_clear();
    #1;
    tests_run++;
    if ({Stall, Pending, Rs_Data} !== {1'b0, 16'h0000, 16'h0000}) begin
      tests_failed++; $display("FAIL mid_reset: got %b/%h/%h want 0/0000/0000", Stall, Pending, Rs_Data);
    end
    @(negedge clk);
    rest = 1;
    #1;
    tests_run++;
    if ({Stall, Pending, Rs_Data} !== {1'b0, 16'h0000, 16'h0000}) begin
      tests_failed++; $display("FAIL post_reset: got %b/%h/%h want 0/0000/0000", Stall, Pending, Rs_Data);
    end
    idle();
    $display("[TB] mid-operation reset checked");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rest         = 0;
    idle();
    model_clear();
    test_reset();
    test_write_read();
    test_bypass();
    test_stall_pending();
    test_count_max();
    test_freeze();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rest  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port Freze  input  1  decode-side hold; blocks issue acceptance.
REQ-004 SHALL have port RegWrite  input  1  write-back write enable.
REQ-005 SHALL have port Rd_In  input  4  write-back destination register.
REQ-006 SHALL have port WriteDataRegFile  input  16  write-back data.
REQ-007 SHALL have ports Rs_Addr, Rt_Addr  input  4 each  read addresses.
REQ-008 SHALL have ports Rs_Used, Rt_Used  input  1 each  instruction in decode consumes Rs / Rt.
REQ-009 SHALL have ports Rs_Data, Rt_Data  output  16 each  read data.
REQ-010 SHALL have port Issue_Valid  input  1  decode presents an instruction for issue.
REQ-011 SHALL have port Issue_RegWrite  input  1  issuing instruction will write a register.
REQ-012 SHALL have port Issue_Rd  input  4  issuing instruction destination.
REQ-013 SHALL have port Stall  output  1  issue blocked this cycle by a hazard.
REQ-014 SHALL have port Pending  output  16  bit n = register n has at least one outstanding write.

Function
REQ-015 SHALL hold 16 x 16-bit registers; R0 reads 0, writes to R0 ignored, R0 never pending.
REQ-016 SHALL write WriteDataRegFile into Rd_In on the rising edge when RegWrite=1 and Rd_In!=0.
REQ-017 SHALL read combinationally; when RegWrite=1, Rd_In==address, address!=0, output SHALL be WriteDataRegFile (same-cycle bypass).
REQ-018 SHALL keep a 2-bit outstanding-write count per register (R1-R15); Pending[n]=(count[n]!=0).
REQ-019 Issue accepted = Issue_Valid & ~Stall & ~Freze; on acceptance with Issue_RegWrite=1 and Issue_Rd!=0, count[Issue_Rd] SHALL increment.
REQ-020 On RegWrite=1, Rd_In!=0, count[Rd_In]!=0, count SHALL decrement; write-back to a register with count 0 SHALL write data, leave count at 0.
REQ-021 Simultaneous accepted increment and decrement on same register SHALL leave count unchanged.
REQ-022 Source hazard on Rs: Rs_Used & Rs_Addr!=0 & count[Rs_Addr]!=0 & ~(count[Rs_Addr]==1 & RegWrite & Rd_In==Rs_Addr); same rule for Rt.
REQ-023 Stall SHALL = Issue_Valid & (Rs hazard | Rt hazard | (Issue_RegWrite & Issue_Rd!=0 & count[Issue_Rd]==3 & ~(RegWrite & Rd_In==Issue_Rd))).
REQ-024 Stall SHALL be combinational, independent of Freze; Freze alone SHALL not change any count.

Reset
REQ-025 rest=0 SHALL immediately clear all registers to 0 and all counts to 0, irrespective of clk.
REQ-026 While and after reset: Pending=0, Stall=0, Rs_Data/Rt_Data=0 unless bypass applies after reset release.
REQ-027 Reset asserted mid-operation SHALL discard all outstanding counts; no write completes in a cycle where rest=0.

Structure
REQ-028 Shared package SHALL hold REG_COUNT=16, DATA_W=16, ADDR_W=4, CNT_W=2, CNT_MAX=3.
REQ-029 SHALL instantiate sub-module sb_counter (one per R1-R15): 2-bit up/down counter with inc, dec, async active-low clear.

Verification
REQ-030 Reset, write R3=0x1234 via RegWrite, then read Rs_Addr=3 -> Rs_Data=0x1234; write R0=0xFFFF -> read R0 = 0.
REQ-031 RegWrite=1, Rd_In=5, data 0xABCD, Rt_Addr=5 same cycle -> Rt_Data=0xABCD (bypass) before edge.
REQ-032 Issue write to R4, next cycle Rs_Used, Rs_Addr=4, Issue_Valid=1 -> Stall=1, Pending[4]=1; WB R4 arrives -> Stall=0 that cycle, Pending[4]=0 next cycle.
REQ-033 Issue three accepted writes to R7 -> count 3; fourth issue to R7 -> Stall=1; WB R7 same cycle -> Stall=0, count stays 3.
REQ-034 Freze=1 with Issue_Valid=1, Issue_Rd=2 -> count[2] unchanged, Pending[2]=0.
REQ-035 Counts R1=2, R9=1, assert rest mid-cycle -> Pending=0 immediately, Rs_Data for R1 = 0.
